// File: rtl/mem_bus_arbiter.sv
// Arbitrates the CPU's single Avalon memory master between fetch and data requesters.
// Optional MEM_ARB_ROUND_ROBIN_EN replaces fixed data-priority tie breaking with round robin.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic                instr_req_i,
  input  logic [ADDR_W-1:0]   instr_addr_i,
  output logic                instr_done_o,
  input  logic                data_req_i,
  input  logic                data_we_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  input  logic [DATA_W/8-1:0] data_be_i,
  output logic                data_done_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                stall_o,
  output logic [ADDR_W-1:0]   avm_address_o,
  output logic                avm_read_o,
  output logic                avm_write_o,
  output logic [DATA_W-1:0]   avm_writedata_o,
  output logic [DATA_W/8-1:0] avm_byteenable_o,
  input  logic                avm_waitrequest_i,
  input  logic [DATA_W-1:0]   avm_readdata_i
);
  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, INSTR_BUS, DATA_BUS, RESP} state_t;

  state_t              state, state_nxt;
  logic                owner_data;
  logic                we_lat;
  logic [ADDR_W-1:0]   addr_lat;
  logic [DATA_W-1:0]   wdata_lat;
  logic [BE_W-1:0]     be_lat;
  logic                any_req;
  logic                grant_data;
  logic                idle_exit;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & {{(ADDR_W-2){1'b1}}, 2'b00};
  endfunction

  assign any_req   = instr_req_i | data_req_i;
  assign idle_exit = (state == IDLE) & any_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // last_data: 1 when the most recent grant went to the data requester
  logic last_data;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      last_data <= 1'b0;
    end else if (idle_exit) begin
      last_data <= grant_data;
    end
  end

  assign grant_data = data_req_i & (~instr_req_i | ~last_data);
`else
  assign grant_data = data_req_i;
`endif

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state      <= IDLE;
      owner_data <= 1'b0;
      we_lat     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (idle_exit) begin
        owner_data <= grant_data;
        we_lat     <= grant_data & data_we_i;
      end
    end
  end

  // Request capture: bus fields are frozen at IDLE exit so requester changes cannot disturb the bus
  always_ff @(posedge clk) begin
    if (idle_exit) begin
      addr_lat  <= grant_data ? word_align(data_addr_i) : word_align(instr_addr_i);
      be_lat    <= grant_data ? data_be_i : '1;
      wdata_lat <= grant_data ? data_wdata_i : '0;
    end
  end

  always_comb begin
    state_nxt        = state;
    avm_address_o    = '0;
    avm_read_o       = 1'b0;
    avm_write_o      = 1'b0;
    avm_writedata_o  = '0;
    avm_byteenable_o = '0;
    instr_done_o     = 1'b0;
    data_done_o      = 1'b0;
    rdata_o          = '0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = grant_data ? DATA_BUS : INSTR_BUS;
        end
      end
      INSTR_BUS, DATA_BUS: begin
        avm_read_o       = ~we_lat;
        avm_write_o      = we_lat;
        avm_address_o    = addr_lat;
        avm_byteenable_o = be_lat;
        avm_writedata_o  = wdata_lat;
        if (!avm_waitrequest_i) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        instr_done_o = ~owner_data;
        data_done_o  = owner_data;
        rdata_o      = we_lat ? '0 : avm_readdata_i;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign stall_o = (instr_req_i & ~instr_done_o) | (data_req_i & ~data_done_o);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios plus randomized traffic against a transaction model.
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i;
  logic          instr_req_i;
  logic [AW-1:0] instr_addr_i;
  logic          instr_done_o;
  logic          data_req_i;
  logic          data_we_i;
  logic [AW-1:0] data_addr_i;
  logic [DW-1:0] data_wdata_i;
  logic [BW-1:0] data_be_i;
  logic          data_done_o;
  logic [DW-1:0] rdata_o;
  logic          stall_o;
  logic [AW-1:0] avm_address_o;
  logic          avm_read_o;
  logic          avm_write_o;
  logic [DW-1:0] avm_writedata_o;
  logic [BW-1:0] avm_byteenable_o;
  logic          avm_waitrequest_i;
  logic [DW-1:0] avm_readdata_i;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_i(reset_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_done_o(instr_done_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_be_i(data_be_i), .data_done_o(data_done_o),
    .rdata_o(rdata_o), .stall_o(stall_o),
    .avm_address_o(avm_address_o), .avm_read_o(avm_read_o), .avm_write_o(avm_write_o),
    .avm_writedata_o(avm_writedata_o), .avm_byteenable_o(avm_byteenable_o),
    .avm_waitrequest_i(avm_waitrequest_i), .avm_readdata_i(avm_readdata_i)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference: 0 = bus free, 1 = transfer on bus, 2 = response cycle
  int            phase = 0;
  logic          cur_data = 1'b0;
  logic          cur_we = 1'b0;
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] cur_wdata = '0;
  logic [BW-1:0] cur_be = '0;
  logic          last_data = 1'b0;
  int            done_cnt = 0;
  logic          seen_idone = 1'b0;
  logic          seen_ddone = 1'b0;
  logic          rand_mode = 1'b0;
  logic          i_hold = 1'b0;
  logic          d_hold = 1'b0;

  always @(negedge clk) begin
    logic          ei, ed, tie_data;
    logic [DW-1:0] er;
    ei = 1'b0;
    ed = 1'b0;
    er = '0;
    if (phase == 1) begin
      chk("bus_read", 64'(avm_read_o), 64'(!cur_we));
      chk("bus_write", 64'(avm_write_o), 64'(cur_we));
      chk("bus_addr", 64'(avm_address_o), 64'(cur_addr));
      chk("bus_be", 64'(avm_byteenable_o), 64'(cur_be));
      chk("bus_wdata", 64'(avm_writedata_o), 64'(cur_wdata));
    end else begin
      chk("quiet_read", 64'(avm_read_o), 64'd0);
      chk("quiet_write", 64'(avm_write_o), 64'd0);
      chk("quiet_addr", 64'(avm_address_o), 64'd0);
      chk("quiet_be", 64'(avm_byteenable_o), 64'd0);
      chk("quiet_wdata", 64'(avm_writedata_o), 64'd0);
    end
    if (phase == 2) begin
      ei = !cur_data;
      ed = cur_data;
      er = cur_we ? '0 : avm_readdata_i;
    end
    chk("instr_done", 64'(instr_done_o), 64'(ei));
    chk("data_done", 64'(data_done_o), 64'(ed));
    chk("rdata", 64'(rdata_o), 64'(er));
    chk("stall", 64'(stall_o), 64'((instr_req_i && !ei) || (data_req_i && !ed)));
    seen_idone = ei;
    seen_ddone = ed;
    if (ei || ed) done_cnt++;
    case (phase)
      0: begin
        if (instr_req_i || data_req_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          tie_data = !last_data;
`else
          tie_data = 1'b1;
`endif
          cur_data  = data_req_i && (!instr_req_i || tie_data);
          cur_we    = cur_data && data_we_i;
          cur_addr  = (cur_data ? data_addr_i : instr_addr_i) & 32'hFFFF_FFFC;
          cur_be    = cur_data ? data_be_i : 4'hF;
          cur_wdata = cur_data ? data_wdata_i : '0;
          last_data = cur_data;
          phase     = 1;
        end
      end
      1: if (!avm_waitrequest_i) phase = 2;
      default: phase = 0;
    endcase
    if (reset_i) begin
      phase     = 0;
      last_data = 1'b0;
      i_hold    = 1'b0;
      d_hold    = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (seen_idone) begin instr_req_i = 1'b0; i_hold = 1'b0; end
    if (seen_ddone) begin data_req_i = 1'b0; d_hold = 1'b0; end
    if (rand_mode) begin
      reset_i           = ($urandom_range(0, 299) == 0);
      avm_waitrequest_i = ($urandom_range(0, 2) == 0);
      avm_readdata_i    = $urandom;
      if (phase == 1 && !cur_data && instr_req_i && $urandom_range(0, 19) == 0) begin
        instr_req_i = 1'b0;
        i_hold      = 1'b1;
      end
      if (phase == 1 && cur_data && data_req_i && $urandom_range(0, 19) == 0) begin
        data_req_i = 1'b0;
        d_hold     = 1'b1;
      end
      if (!instr_req_i) begin
        instr_addr_i = $urandom;
        if (!i_hold && $urandom_range(0, 2) == 0) instr_req_i = 1'b1;
      end
      if (!data_req_i) begin
        data_we_i    = 1'($urandom_range(0, 1));
        data_addr_i  = $urandom;
        data_wdata_i = $urandom;
        data_be_i    = 4'($urandom_range(0, 15));
        if (!d_hold && $urandom_range(0, 2) == 0) data_req_i = 1'b1;
      end
    end
  endtask

  initial begin
    logic          exp_first_data;
    logic          got;
    int            n;
    reset_i = 1'b1;
    instr_req_i = 1'b0; instr_addr_i = '0;
    data_req_i = 1'b0; data_we_i = 1'b0; data_addr_i = '0; data_wdata_i = '0; data_be_i = '0;
    avm_waitrequest_i = 1'b0; avm_readdata_i = 32'hCAFE_F00D;
    step(); step();
    reset_i = 1'b0;
    @(negedge clk);
    chk("rst_read", 64'(avm_read_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);

    // Fetch with no wait states
    step();
    instr_addr_i = 32'h0040_0004; instr_req_i = 1'b1;
    @(negedge clk);
    chk("t1_stall_req", 64'(stall_o), 64'd1);
    step(); @(negedge clk);
    chk("t1_read", 64'(avm_read_o), 64'd1);
    chk("t1_addr", 64'(avm_address_o), 64'h0040_0004);
    chk("t1_be", 64'(avm_byteenable_o), 64'hF);
    step(); @(negedge clk);
    chk("t1_done", 64'(instr_done_o), 64'd1);
    chk("t1_rdata", 64'(rdata_o), 64'hCAFE_F00D);
    chk("t1_stall_done", 64'(stall_o), 64'd0);
    step(); @(negedge clk);
    chk("t1_stall_after", 64'(stall_o), 64'd0);

    // Write with three wait states
    data_we_i = 1'b1; data_addr_i = 32'h0000_1003; data_be_i = 4'b0010;
    data_wdata_i = 32'hDEAD_BEEF; data_req_i = 1'b1; avm_waitrequest_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      avm_waitrequest_i = (k < 4);
      @(negedge clk);
      chk("t2_write", 64'(avm_write_o), 64'd1);
      chk("t2_addr", 64'(avm_address_o), 64'h1000);
      chk("t2_be", 64'(avm_byteenable_o), 64'h2);
      chk("t2_wdata", 64'(avm_writedata_o), 64'hDEAD_BEEF);
      chk("t2_nodone", 64'(data_done_o), 64'd0);
    end
    step(); @(negedge clk);
    chk("t2_done", 64'(data_done_o), 64'd1);
    chk("t2_rdata", 64'(rdata_o), 64'd0);
    step();

    // Simultaneous requests
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_first_data = 1'b0;
`else
    exp_first_data = 1'b1;
`endif
    avm_waitrequest_i = 1'b0;
    data_we_i = 1'b0; data_addr_i = 32'h2000; data_be_i = 4'hF;
    instr_addr_i = 32'h3000;
    data_req_i = 1'b1; instr_req_i = 1'b1;
    step(); @(negedge clk);
    chk("t3_first_addr", 64'(avm_address_o), exp_first_data ? 64'h2000 : 64'h3000);
    step(); @(negedge clk);
    chk("t3_first_done", 64'(exp_first_data ? data_done_o : instr_done_o), 64'd1);
    chk("t3_loser_stall", 64'(stall_o), 64'd1);
    step(); @(negedge clk);
    chk("t3_gap_read", 64'(avm_read_o), 64'd0);
    step(); @(negedge clk);
    chk("t3_second_addr", 64'(avm_address_o), exp_first_data ? 64'h3000 : 64'h2000);
    step(); @(negedge clk);
    chk("t3_second_done", 64'(exp_first_data ? instr_done_o : data_done_o), 64'd1);
    step();

    // Reset while a data read is held by waitrequest
    data_we_i = 1'b0; data_addr_i = 32'h4000; data_be_i = 4'hF;
    data_req_i = 1'b1; avm_waitrequest_i = 1'b1;
    step(); step();
    reset_i = 1'b1;
    @(negedge clk);
    chk("t4_bus_held", 64'(avm_read_o), 64'd1);
    step();
    reset_i = 1'b0;
    @(negedge clk);
    chk("t4_rst_read", 64'(avm_read_o), 64'd0);
    chk("t4_rst_done", 64'(data_done_o), 64'd0);
    chk("t4_rst_stall", 64'(stall_o), 64'd1);
    avm_waitrequest_i = 1'b0;
    got = 1'b0; n = 0;
    while (!got && n < 10) begin
      step(); @(negedge clk);
      got = data_done_o;
      n++;
    end
    chk("t4_reserved", 64'(got), 64'd1);
    step();

    // Idle bus
    for (int k = 0; k < 10; k++) begin
      step(); @(negedge clk);
      chk("idle_read", 64'(avm_read_o), 64'd0);
      chk("idle_addr", 64'(avm_address_o), 64'd0);
      chk("idle_stall", 64'(stall_o), 64'd0);
    end

    // Randomized traffic
    rand_mode = 1'b1;
    n = done_cnt;
    repeat (3000) step();
    rand_mode = 1'b0;
    reset_i = 1'b0;
    step(); step();
    chk("rand_progress", 64'((done_cnt - n) > 200), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
